// File: rtl/booth_wallace_mult_pipe_if.sv
// Operand-issue and result-writeback bundle for booth_wallace_mult_pipe.
// The slave side is the multiplier; the master side issues and drains.
interface booth_wallace_mult_pipe_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_p;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_signed, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/booth_wallace_mult_pipe.sv
// Radix-4 Booth multiplier with a 3:2 Wallace tree and final adder, 3-stage pipe.
// Define MULT_TREE_SPLIT_EN to register the tree at its midpoint (4-cycle latency).
module booth_wallace_mult_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
    booth_wallace_mult_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int N  = WIDTH / 2 + 1;
    localparam int R  = N + 1;

    function automatic int rows_at(int lvl);
        int r = R;
        for (int k = 0; k < lvl; k++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    function automatic int num_levels();
        int r = R;
        int n = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + r % 3;
            n++;
        end
        return n;
    endfunction

    localparam int L = num_levels();

    logic stall;
    logic adv;
    logic out_valid_q;

    assign stall = out_valid_q & ~bus.out_ready;
    assign adv = ~stall;
    assign bus.in_ready = adv;

    // S1: Booth encode; b is padded with an implicit 0 below the LSB
    logic [PW-1:0]    a_ext;
    logic [WIDTH+2:0] b_sel;
    logic [PW-1:0]    pp_d [N];
    logic [N-1:0]     neg_d;

    assign a_ext = {{WIDTH{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
    assign b_sel = {{2{bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b, 1'b0};

    for (genvar i = 0; i < N; i++) begin : g_enc
        logic [2:0]    d;
        logic          one;
        logic          two;
        logic [PW-1:0] m;
        assign d = b_sel[2*i +: 3];
        assign one = d[1] ^ d[0];
        assign two = (d == 3'b011) | (d == 3'b100);
        assign neg_d[i] = d[2] & ~(d[1] & d[0]);
        assign m = two ? (a_ext << 1) : (one ? a_ext : '0);
        // ~m << 2i needs +2^(2i) to become -(m << 2i); that bit rides in neg_q
        assign pp_d[i] = (neg_d[i] ? ~m : m) << (2 * i);
    end

    logic             v1_q;
    logic [TAG_W-1:0] tag1_q;
    logic [PW-1:0]    pp_q [N];
    logic [N-1:0]     neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            tag1_q <= '0;
            neg_q  <= '0;
            for (int i = 0; i < N; i++) pp_q[i] <= '0;
        end else if (adv) begin
            v1_q   <= bus.in_valid;
            tag1_q <= bus.in_tag;
            neg_q  <= neg_d;
            for (int i = 0; i < N; i++) pp_q[i] <= pp_d[i];
        end
    end

    // S2: carry-save reduction
    logic [PW-1:0] corr;
    logic [PW-1:0] lvl [L+1][R];

    always_comb begin
        corr = '0;
        for (int k = 0; k < N; k++) corr[2*k] = neg_q[k];
    end

    for (genvar i = 0; i < N; i++) begin : g_l0
        assign lvl[0][i] = pp_q[i];
    end
    assign lvl[0][N] = corr;

    logic             v2_src;
    logic [TAG_W-1:0] tag2_src;

`ifdef MULT_TREE_SPLIT_EN
    localparam int SPLIT = (L + 1) / 2;

    logic             vm_q;
    logic [TAG_W-1:0] tagm_q;
    logic [PW-1:0]    mid_q [R];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vm_q   <= 1'b0;
            tagm_q <= '0;
            for (int k = 0; k < R; k++) mid_q[k] <= '0;
        end else if (adv) begin
            vm_q   <= v1_q;
            tagm_q <= tag1_q;
            for (int k = 0; k < R; k++) mid_q[k] <= lvl[SPLIT][k];
        end
    end

    assign v2_src = vm_q;
    assign tag2_src = tagm_q;
`else
    assign v2_src = v1_q;
    assign tag2_src = tag1_q;
`endif

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int RI = rows_at(l);
        localparam int G  = RI / 3;
        localparam int RO = rows_at(l + 1);
        logic [PW-1:0] src [R];

        for (genvar k = 0; k < R; k++) begin : g_src
`ifdef MULT_TREE_SPLIT_EN
            if (l == SPLIT) begin : g_reg
                assign src[k] = mid_q[k];
            end else begin : g_cmb
                assign src[k] = lvl[l][k];
            end
`else
            assign src[k] = lvl[l][k];
`endif
        end

        for (genvar j = 0; j < G; j++) begin : g_fa
            logic [PW-1:0] x;
            logic [PW-1:0] y;
            logic [PW-1:0] z;
            logic [PW-1:0] maj;
            assign x = src[3*j];
            assign y = src[3*j+1];
            assign z = src[3*j+2];
            assign maj = (x & y) | (x & z) | (y & z);
            assign lvl[l+1][2*j] = x ^ y ^ z;
            assign lvl[l+1][2*j+1] = {maj[PW-2:0], 1'b0};
        end

        for (genvar k = 0; k < RI - 3 * G; k++) begin : g_pass
            assign lvl[l+1][2*G+k] = src[3*G+k];
        end

        for (genvar k = RO; k < R; k++) begin : g_pad
            assign lvl[l+1][k] = '0;
        end
    end

    logic             v2_q;
    logic [TAG_W-1:0] tag2_q;
    logic [PW-1:0]    s_q;
    logic [PW-1:0]    c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            tag2_q <= '0;
            s_q    <= '0;
            c_q    <= '0;
        end else if (adv) begin
            v2_q   <= v2_src;
            tag2_q <= tag2_src;
            s_q    <= lvl[L][0];
            c_q    <= lvl[L][1];
        end
    end

    // S3: carry-propagate add into the output register
    logic [PW-1:0]    p_d;
    logic [PW-1:0]    p_q;
    logic [TAG_W-1:0] tag3_q;

    assign p_d = c_q + s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            tag3_q      <= '0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            p_q         <= p_d;
            tag3_q      <= tag2_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_p = p_q;
    assign bus.out_tag = tag3_q;
endmodule
